// File: rtl/rgb2gray_pkg.sv
// Shared definitions for the RGB-to-grayscale converter.
// Luma weights are in 1/64 units, and each weight set sums to 64.
package rgb2gray_pkg;

    localparam int unsigned COEF_SHIFT = 6;
    localparam int unsigned COEF_W     = 7;

    typedef enum logic [1:0] {
        MODE_BT601  = 2'd0,
        MODE_BT709  = 2'd1,
        MODE_AVG    = 2'd2,
        MODE_THRESH = 2'd3
    } mode_e;

    localparam logic [COEF_W-1:0] WR_601 = 7'd20;
    localparam logic [COEF_W-1:0] WG_601 = 7'd36;
    localparam logic [COEF_W-1:0] WB_601 = 7'd8;

    localparam logic [COEF_W-1:0] WR_709 = 7'd14;
    localparam logic [COEF_W-1:0] WG_709 = 7'd45;
    localparam logic [COEF_W-1:0] WB_709 = 7'd5;

    localparam logic [COEF_W-1:0] WR_AVG = 7'd21;
    localparam logic [COEF_W-1:0] WG_AVG = 7'd22;
    localparam logic [COEF_W-1:0] WB_AVG = 7'd21;

endpackage

// File: rtl/rgb2gray_wsum.sv
// Stage 2: registered three-term weighted sum, floor-divided by 64.
// The sum is IN_W+6 bits wide, which cannot overflow because the weights total 64.
module rgb2gray_wsum
    import rgb2gray_pkg::*;
#(
    parameter int unsigned IN_W = 12
) (
    input  logic              iCLK,
    input  logic              iReset_n,
    input  logic [COEF_W-1:0] iWr,
    input  logic [COEF_W-1:0] iWg,
    input  logic [COEF_W-1:0] iWb,
    input  logic [IN_W-1:0]   iRed,
    input  logic [IN_W-1:0]   iGreen,
    input  logic [IN_W-1:0]   iBlue,
    output logic [IN_W-1:0]   oLum
);

    localparam int unsigned SUM_W = IN_W + COEF_SHIFT;

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = SUM_W'(iWr) * SUM_W'(iRed)
            + SUM_W'(iWg) * SUM_W'(iGreen)
            + SUM_W'(iWb) * SUM_W'(iBlue);
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n)
            oLum <= '0;
        else
            oLum <= IN_W'(sum >> COEF_SHIFT);
    end

endmodule

// File: rtl/rgb2gray_pipe.sv
// Three-stage RGB-to-gray/threshold converter with frame-synchronous mode/threshold shadow.
// Valid and X/Y coordinates are delayed to stay aligned with the pixel.
module rgb2gray_pipe
    import rgb2gray_pkg::*;
#(
    parameter int unsigned IN_W    = 12,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned COORD_W = 16
) (
    input  logic               iCLK,
    input  logic               iReset_n,
    input  logic [IN_W-1:0]    iRed,
    input  logic [IN_W-1:0]    iGreen,
    input  logic [IN_W-1:0]    iBlue,
    input  logic               iDval,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    input  logic [1:0]         iMode,
    input  logic [OUT_W-1:0]   iThresh,
    output logic [OUT_W-1:0]   oGray,
    output logic               oDval,
    output logic [COORD_W-1:0] oX_Cont,
    output logic [COORD_W-1:0] oY_Cont
);

    localparam logic [OUT_W-1:0] THRESH_RST = OUT_W'(1) << (OUT_W - 1);

    mode_e              shadowMode, pixMode, mode1, mode2;
    logic [OUT_W-1:0]   shadowThresh, pixThresh, thr1, thr2;
    logic               frameStart;

    logic [IN_W-1:0]    red1, green1, blue1;
    logic               dval1, dval2;
    logic [COORD_W-1:0] x1, y1, x2, y2;

    logic [COEF_W-1:0]  wr, wg, wb;
    logic [IN_W-1:0]    lum;
    logic [OUT_W-1:0]   gray;

    // The (0,0) pixel that loads a new config also uses that config.
    always_comb begin
        frameStart = iDval && (iX_Cont == '0) && (iY_Cont == '0);
        pixMode    = frameStart ? mode_e'(iMode) : shadowMode;
        pixThresh  = frameStart ? iThresh : shadowThresh;
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            shadowMode   <= MODE_BT601;
            shadowThresh <= THRESH_RST;
        end else begin
            shadowMode   <= pixMode;
            shadowThresh <= pixThresh;
        end
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            red1   <= '0;
            green1 <= '0;
            blue1  <= '0;
            dval1  <= 1'b0;
            x1     <= '0;
            y1     <= '0;
            mode1  <= MODE_BT601;
            thr1   <= THRESH_RST;
        end else begin
            red1   <= iRed;
            green1 <= iGreen;
            blue1  <= iBlue;
            dval1  <= iDval;
            x1     <= iX_Cont;
            y1     <= iY_Cont;
            mode1  <= pixMode;
            thr1   <= pixThresh;
        end
    end

    always_comb begin
        wr = WR_601;
        wg = WG_601;
        wb = WB_601;
        case (mode1)
            MODE_BT709: begin wr = WR_709; wg = WG_709; wb = WB_709; end
            MODE_AVG:   begin wr = WR_AVG; wg = WG_AVG; wb = WB_AVG; end
            default:    begin wr = WR_601; wg = WG_601; wb = WB_601; end
        endcase
    end

    rgb2gray_wsum #(
        .IN_W(IN_W)
    ) uWsum (
        .iCLK    (iCLK),
        .iReset_n(iReset_n),
        .iWr     (wr),
        .iWg     (wg),
        .iWb     (wb),
        .iRed    (red1),
        .iGreen  (green1),
        .iBlue   (blue1),
        .oLum    (lum)
    );

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            dval2 <= 1'b0;
            x2    <= '0;
            y2    <= '0;
            mode2 <= MODE_BT601;
            thr2  <= THRESH_RST;
        end else begin
            dval2 <= dval1;
            x2    <= x1;
            y2    <= y1;
            mode2 <= mode1;
            thr2  <= thr1;
        end
    end

    always_comb begin
        gray = OUT_W'(lum >> (IN_W - OUT_W));
    end

    always_ff @(posedge iCLK or negedge iReset_n) begin
        if (!iReset_n) begin
            oGray   <= '0;
            oDval   <= 1'b0;
            oX_Cont <= '0;
            oY_Cont <= '0;
        end else begin
            oDval   <= dval2;
            oX_Cont <= x2;
            oY_Cont <= y2;
            if (!dval2)
                oGray <= '0;
            else if (mode2 == MODE_THRESH)
                oGray <= (gray >= thr2) ? '1 : '0;
            else
                oGray <= gray;
        end
    end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Directed and random stimulus for rgb2gray_pipe.
// Every output is checked against an arithmetic reference model delayed by three cycles.
module tb_rgb2gray_pipe;

    localparam int IN_W    = 12;
    localparam int OUT_W   = 8;
    localparam int COORD_W = 16;

    logic               iCLK = 1'b0;
    logic               iReset_n = 1'b0;
    logic [IN_W-1:0]    iRed = '0, iGreen = '0, iBlue = '0;
    logic               iDval = 1'b0;
    logic [COORD_W-1:0] iX_Cont = '0, iY_Cont = '0;
    logic [1:0]         iMode = '0;
    logic [OUT_W-1:0]   iThresh = '0;
    logic [OUT_W-1:0]   oGray;
    logic               oDval;
    logic [COORD_W-1:0] oX_Cont, oY_Cont;

    typedef struct {
        logic               dv;
        logic [OUT_W-1:0]   gray;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned mMode  = 0;
    int unsigned mThr   = 128;

    rgb2gray_pipe #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .COORD_W(COORD_W)
    ) dut (
        .iCLK    (iCLK),
        .iReset_n(iReset_n),
        .iRed    (iRed),
        .iGreen  (iGreen),
        .iBlue   (iBlue),
        .iDval   (iDval),
        .iX_Cont (iX_Cont),
        .iY_Cont (iY_Cont),
        .iMode   (iMode),
        .iThresh (iThresh),
        .oGray   (oGray),
        .oDval   (oDval),
        .oX_Cont (oX_Cont),
        .oY_Cont (oY_Cont)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [OUT_W-1:0] refGray(int unsigned mode, int unsigned thr,
                                                 int unsigned r, int unsigned g, int unsigned b);
        int unsigned wr, wg, wb, lum, gr;
        case (mode)
            1:       begin wr = 14; wg = 45; wb = 5;  end
            2:       begin wr = 21; wg = 22; wb = 21; end
            default: begin wr = 20; wg = 36; wb = 8;  end
        endcase
        lum = (wr * r + wg * g + wb * b) / 64;
        gr  = lum / (1 << (IN_W - OUT_W));
        if (mode == 3)
            return (gr >= thr) ? 8'hFF : 8'h00;
        return 8'(gr);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic checkOut();
        exp_t e;
        e = q.pop_front();
        chk("oDval", 32'(oDval), 32'(e.dv));
        chk("oGray", 32'(oGray), 32'(e.gray));
        chk("oX_Cont", 32'(oX_Cont), 32'(e.x));
        chk("oY_Cont", 32'(oY_Cont), 32'(e.y));
    endtask

    task automatic checkReset(string tag);
        chk({tag, "_oDval"}, 32'(oDval), 32'd0);
        chk({tag, "_oGray"}, 32'(oGray), 32'd0);
        chk({tag, "_oX"}, 32'(oX_Cont), 32'd0);
        chk({tag, "_oY"}, 32'(oY_Cont), 32'd0);
    endtask

    // Model state after reset: empty pipe (three zero beats), BT601, threshold 128.
    task automatic flushModel();
        exp_t z;
        z.dv = 1'b0; z.gray = '0; z.x = '0; z.y = '0;
        q.delete();
        mMode = 0;
        mThr  = 128;
        repeat (3) q.push_back(z);
    endtask

    task automatic step(logic dv, int unsigned r, int unsigned g, int unsigned b,
                        int unsigned x, int unsigned y, int unsigned mode, int unsigned thr);
        exp_t e;
        @(posedge iCLK);
        #1;
        checkOut();
        iDval   = dv;
        iRed    = 12'(r);
        iGreen  = 12'(g);
        iBlue   = 12'(b);
        iX_Cont = 16'(x);
        iY_Cont = 16'(y);
        iMode   = 2'(mode);
        iThresh = 8'(thr);
        if (dv && x == 0 && y == 0) begin
            mMode = mode;
            mThr  = thr;
        end
        e.dv   = dv;
        e.x    = 16'(x);
        e.y    = 16'(y);
        e.gray = dv ? refGray(mMode, mThr, r, g, b) : 8'h00;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int unsigned rc();
        return $urandom_range(0, 4095);
    endfunction

    initial begin
        flushModel();
        #12;
        checkReset("rst");
        @(posedge iCLK);
        #3 iReset_n = 1'b1;

        // White pixel at frame start, BT601
        step(1'b1, 4095, 4095, 4095, 0, 0, 0, 128);
        idle(4);

        // Pure red BT601, then pure green BT709 loaded at (0,0)
        step(1'b1, 4095, 0, 0, 1, 0, 0, 0);
        step(1'b1, 0, 4095, 0, 0, 0, 1, 0);
        idle(3);

        // Threshold mode around 128, equality counts as on
        step(1'b1, 2048, 2048, 2048, 0, 0, 3, 128);
        step(1'b1, 2032, 2032, 2032, 1, 0, 3, 128);
        step(1'b1, 2048, 2048, 2048, 2, 0, 0, 0);
        idle(3);

        // Mid-frame mode change ignored until next valid (0,0)
        step(1'b1, rc(), rc(), rc(), 0, 0, 0, 128);
        for (int unsigned x = 1; x < 10; x++)
            step(1'b1, rc(), rc(), rc(), x, 0, (x >= 5) ? 1 : 0, 0);
        step(1'b0, rc(), rc(), rc(), 0, 0, 1, 0);
        step(1'b1, rc(), rc(), rc(), 1, 0, 1, 0);
        step(1'b1, rc(), rc(), rc(), 0, 0, 1, 0);
        for (int unsigned x = 1; x < 5; x++)
            step(1'b1, rc(), rc(), rc(), x, 0, 0, 0);

        // Ten-pixel burst with one gap beat
        for (int unsigned i = 0; i < 11; i++)
            step(i != 4, rc(), rc(), rc(), i, 3, $urandom_range(0, 3), $urandom_range(0, 255));
        idle(3);

        // Asynchronous reset mid-burst
        step(1'b1, rc(), rc(), rc(), 0, 0, 3, 40);
        for (int unsigned i = 1; i < 5; i++)
            step(1'b1, rc(), rc(), rc(), i, 0, 3, 40);
        @(posedge iCLK);
        #3 iReset_n = 1'b0;
        iDval = 1'b0; iRed = '0; iGreen = '0; iBlue = '0;
        iX_Cont = '0; iY_Cont = '0; iMode = '0; iThresh = '0;
        #1;
        checkReset("midrst");
        flushModel();
        @(posedge iCLK);
        #3 iReset_n = 1'b1;
        for (int unsigned i = 1; i < 6; i++)
            step(1'b1, rc(), rc(), rc(), i, 2, 1, 0);
        idle(3);

        // Random traffic with frequent frame starts
        repeat (300)
            step($urandom_range(0, 3) != 0, rc(), rc(), rc(),
                 $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 255));
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb2gray_pipe.md
Name: rgb2gray_pipe

Overview:
Parametrised RGB-to-grayscale converter for the camera-to-LCD video path. It sits between the Bayer/RGB reconstruction stage and the frame-buffer writer.
- Selectable luma coefficient sets plus a binary-threshold mode.
- Configurable input and output widths.
- Frame-synchronous mode/threshold update.
- Fixed 3-cycle pipeline; valid and X/Y coordinates are delay-matched to the pixel.

Parameters:
IN_W, 12, colour component width (bits)
OUT_W, 8, gray output width; legal range 1..IN_W
COORD_W, 16, X/Y coordinate width

Ports:
iCLK  in  1  clock
iReset_n  in  1  reset: asynchronous, active-low
iRed  in  IN_W  red component
iGreen  in  IN_W  green component
iBlue  in  IN_W  blue component
iDval  in  1  input pixel valid
iX_Cont  in  COORD_W  input pixel column
iY_Cont  in  COORD_W  input pixel row
iMode  in  2  requested mode: 0=BT601, 1=BT709, 2=AVG, 3=THRESH
iThresh  in  OUT_W  requested threshold for mode 3
oGray  out  OUT_W  gray / binary pixel
oDval  out  1  output valid
oX_Cont  out  COORD_W  delayed column
oY_Cont  out  COORD_W  delayed row

Behaviour:
- Reset is asynchronous: every pipeline register clears.
  - oGray=0, oDval=0, oX_Cont=0, oY_Cont=0.
  - Active mode=0 (BT601); active threshold=2^(OUT_W-1).
- No stall and no backpressure: the pipeline advances every clock. Invalid beats propagate with valid=0.
- Latency is exactly 3 cycles: input at edge N appears on the outputs after edge N+3. Valid, X and Y use the same 3-stage delay.
- Stage 1: register R, G, B, valid, X, Y, and the active mode/threshold for this pixel.
- Frame-synchronous config (shadow registers):
  - When iDval=1, iX_Cont=0 and iY_Cont=0 in the same cycle, the shadow mode and threshold load iMode and iThresh.
  - That pixel already uses the new values.
  - At all other times iMode and iThresh are ignored; mid-frame changes take effect at the next (0,0) valid pixel.
  - A (0,0) beat with iDval=0 does not update the shadow registers.
- Stage 2: sum = Wr*R + Wg*G + Wb*B, with weights in 1/64 units. Each weight set sums to 64.
  - BT601: Wr=20, Wg=36, Wb=8.
  - BT709: Wr=14, Wg=45, Wb=5.
  - AVG: Wr=21, Wg=22, Wb=21.
  - THRESH: uses the BT601 weights.
- Width rules:
  - sum is IN_W+6 bits; overflow is impossible because the maximum is 64*(2^IN_W-1).
  - lum = sum >> 6 (floor), IN_W bits.
  - gray = lum[IN_W-1 -: OUT_W], i.e. truncation with no rounding.
- Stage 3:
  - Modes 0–2: oGray=gray.
  - Mode 3: oGray = all ones if gray >= threshold, else 0. Equality counts as on.
  - Whenever the stage-3 valid is 0, oGray=0.
- Each pixel carries its own mode and threshold through the pipe. A config change at (0,0) never alters pixels already in flight.
- Reset mid-stream: all outputs drop to reset values immediately (asynchronously). In-flight pixels are discarded. The first output after release is the pixel entered at the 1st edge post-release, 3 cycles later.
- Back-to-back valid pixels give back-to-back outputs at a throughput of 1 pixel/clock.

Decomposition:
- Package rgb2gray_pkg holds:
  - mode enum: MODE_BT601, MODE_BT709, MODE_AVG, MODE_THRESH
  - weight constants W*_601, W*_709, W*_AVG
  - COEF_SHIFT=6 and COEF_W=7
- One sub-module, rgb2gray_wsum: the registered 3-term weighted sum plus shift (stage 2). It takes the 3 weights as inputs, selected by the per-pixel mode in the parent.
- The parent owns the shadow config, the delay lines and the threshold/output stage.

Test Plan:
All scenarios use defaults (IN_W=12, OUT_W=8).
1. Reset, then R=G=B=4095, valid, (0,0), mode 0 -> 3 cycles later oGray=255, oDval=1, oX=0, oY=0; nothing before that.
2. Mode 0, R=4095, G=B=0 -> oGray=79 (81900>>6=1279, top 8 bits). Mode 1 at the next (0,0), G=4095 only -> oGray=179.
3. Mode 3, iThresh=128 loaded at (0,0); gray input R=G=B=2048 -> 255; R=G=B=2032 -> 0.
4. Frame in mode 0; at X=5 drive iMode=1 -> pixels X>=5 stay BT601. The next (0,0) valid pixel and all after it are BT709. A (0,0) beat with iDval=0 causes no update.
5. Continuous 10-pixel valid burst with one gap beat -> output valid pattern is identical, shifted 3 cycles; coordinates match per pixel; oGray=0 on the gap.
6. Assert iReset_n low for 1 cycle mid-burst -> oDval=0 immediately; mode reverts to BT601, threshold to 128; outputs resume 3 cycles after the first post-reset valid pixel.
